// File: rtl/gl_cmd_parser.sv
// -----------------------------------------------------------------------------
// gl_cmd_parser
//
// Parses an ASCII command stream from a UART receiver into NOPS hex operands
// followed by a '+' or '-' operator, then launches an arithmetic unit and
// waits for it to finish. Every accepted character is echoed back to the UART
// transmitter once the transmitter is free.
//
// Command grammar (NOPS*NDIG hex digits, then an operator):
//   HEX  '0'-'9', 'a'-'f', 'A'-'F'  -> digit, entered MSB first per operand
//   OP   '+' / '-'                  -> selects add / subtract, starts the op
//   BS   0x08                       -> removes the last digit
//   ESC  0x1B                       -> discards the whole command
//   anything else is ignored (no state change, no echo)
//
// Parameters:
//   NOPS  operands captured per command (1..8)
//   NDIG  hex digits per operand (1..8); operand width W = 4*NDIG
//
// Ports:
//   clk            sole clock, rising edge
//   Gl_rst         synchronous active-high reset
//   charData       received ASCII character
//   charDataValid  one-cycle strobe qualifying charData
//   tx_busy        UART transmitter busy; holds back the echo
//   op_done        one-cycle completion pulse from the arithmetic unit
//   Gl_operands    captured operands, operand k at bits [k*W +: W]
//   Gl_subtract    1 for '-', 0 for '+'
//   Gl_start       one-cycle launch pulse for the arithmetic unit
//   echo_data      character to echo
//   echo_valid     one-cycle write strobe for echo_data
//   busy           high while an operation is launched or in flight
// -----------------------------------------------------------------------------
module gl_cmd_parser #(
  parameter int NOPS = 2,
  parameter int NDIG = 2
) (
  input  logic                     clk,
  input  logic                     Gl_rst,
  input  logic [7:0]               charData,
  input  logic                     charDataValid,
  input  logic                     tx_busy,
  input  logic                     op_done,
  output logic [NOPS*4*NDIG-1:0]   Gl_operands,
  output logic                     Gl_subtract,
  output logic                     Gl_start,
  output logic [7:0]               echo_data,
  output logic                     echo_valid,
  output logic                     busy
);

  localparam int W       = 4 * NDIG;
  localparam int OPW     = NOPS * W;
  localparam int NDIGITS = NOPS * NDIG;
  localparam int DW      = $clog2(NDIGITS + 1);

  localparam logic [DW-1:0] D_FULL = DW'(NDIGITS);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_BS    = 8'h08;

  typedef enum logic [1:0] {
    S_DIGITS = 2'd0,
    S_OPER   = 2'd1,
    S_START  = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  // Bit offset of the nibble written by digit number d. Digit d belongs to
  // operand d/NDIG; within that operand the first digit lands in the top
  // nibble so the operand reads left to right as typed.
  function automatic int nib_lsb(input logic [DW-1:0] d);
    int di;
    di = int'(d);
    return (di / NDIG) * W + (NDIG - 1 - (di % NDIG)) * 4;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [DW-1:0]     d_q, d_d;
  logic [OPW-1:0]    ops_q, ops_d;
  logic              sub_q, sub_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              pend_q, pend_d;
  logic [7:0]        echo_data_q, echo_data_d;

  // ---------------------------------------------------------------------------
  // Character classification
  // ---------------------------------------------------------------------------
  logic       is_dec, is_lc, is_uc, is_hex, is_op, is_esc, is_bs;
  logic [3:0] hex_val;

  always_comb begin
    is_dec  = (charData >= 8'h30) && (charData <= 8'h39);
    is_lc   = (charData >= 8'h61) && (charData <= 8'h66);
    is_uc   = (charData >= 8'h41) && (charData <= 8'h46);
    is_hex  = is_dec || is_lc || is_uc;
    is_op   = (charData == CH_PLUS) || (charData == CH_MINUS);
    is_esc  = (charData == CH_ESC);
    is_bs   = (charData == CH_BS);
    // Letters 'a'/'A' have low nibble 1, so adding 9 yields 10..15.
    hex_val = is_dec ? charData[3:0] : (charData[3:0] + 4'd9);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic          accept;
  logic          echo_take;
  logic [DW-1:0] d_inc, d_dec;
  int            lsb_cur, lsb_dec;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise this block would infer latches.
    state_d     = state_q;
    d_d         = d_q;
    ops_d       = ops_q;
    sub_d       = sub_q;
    pend_d      = pend_q;
    echo_data_d = echo_data_q;
    echo_take   = 1'b0;

    d_inc   = d_q + D_ONE;
    d_dec   = d_q - D_ONE;
    lsb_cur = nib_lsb(d_q);
    lsb_dec = nib_lsb(d_dec);

    // Acceptance looks only at the registered pending flag, so a character
    // arriving in the cycle the echo drains is still dropped.
    accept = charDataValid && !pend_q;

    // The pending echo leaves in the first cycle the transmitter is free.
    if (pend_q && !tx_busy) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      S_DIGITS: begin
        if (accept) begin
          if (is_esc) begin
            d_d       = '0;
            ops_d     = '0;
            echo_take = 1'b1;
          end else if (is_hex) begin
            ops_d[lsb_cur +: 4] = hex_val;
            d_d       = d_inc;
            echo_take = 1'b1;
            if (d_inc == D_FULL) begin
              state_d = S_OPER;
            end
          end else if (is_bs && (d_q != '0)) begin
            // BS at d=0 has nothing to remove and is neither applied nor echoed.
            ops_d[lsb_dec +: 4] = 4'h0;
            d_d       = d_dec;
            echo_take = 1'b1;
          end
        end
      end

      S_OPER: begin
        // All digits are in; only an operator, BS or ESC does anything here.
        if (accept) begin
          if (is_esc) begin
            d_d       = '0;
            ops_d     = '0;
            state_d   = S_DIGITS;
            echo_take = 1'b1;
          end else if (is_op) begin
            sub_d     = (charData == CH_MINUS);
            state_d   = S_START;
            echo_take = 1'b1;
          end else if (is_bs) begin
            ops_d[lsb_dec +: 4] = 4'h0;
            d_d       = d_dec;
            state_d   = S_DIGITS;
            echo_take = 1'b1;
          end
        end
      end

      S_START: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Input is ignored while the arithmetic unit runs. The operands are
        // left in place so the unit can keep reading them.
        if (op_done) begin
          d_d     = '0;
          state_d = S_DIGITS;
        end
      end

      default: begin
        state_d = S_DIGITS;
      end
    endcase

    // accept requires pend_q=0 and the drain requires pend_q=1, so the two
    // updates of pend_d never collide.
    if (echo_take) begin
      pend_d      = 1'b1;
      echo_data_d = charData;
    end

    // Outputs are registered from the next state so they line up with it.
    start_d = (state_d == S_START);
    busy_d  = (state_d == S_START) || (state_d == S_WAIT);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values computed before the edge.
  always_ff @(posedge clk) begin
    if (Gl_rst) begin
      state_q     <= S_DIGITS;
      d_q         <= '0;
      // NOTE: the operand register is reset on purpose: a cleared command is
      // observable on Gl_operands, so it must come up at zero.
      ops_q       <= '0;
      sub_q       <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      echo_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      ops_q       <= ops_d;
      sub_q       <= sub_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      echo_data_q <= echo_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Gl_operands = ops_q;
  assign Gl_subtract = sub_q;
  assign Gl_start    = start_q;
  assign busy        = busy_q;
  assign echo_data   = echo_data_q;
  // The strobe follows tx_busy directly so the echo leaves in the very cycle
  // the transmitter frees up, one cycle after acceptance at the earliest.
  assign echo_valid  = pend_q && !tx_busy;

endmodule
